// File: rtl/gpr_file_dbg.sv
// General-purpose register file: two combinational read ports, one write port,
// optional hardwired-zero r0, optional write-to-read bypass, and a debug dump
// engine that streams every register out over a valid/ready port.
module gpr_file_dbg #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = ($clog2(NUM_REGS) < 1) ? 1 : $clog2(NUM_REGS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [AW-1:0]    i_rd_addr_a,
    output logic [WIDTH-1:0] o_rd_data_a,
    input  logic [AW-1:0]    i_rd_addr_b,
    output logic [WIDTH-1:0] o_rd_data_b,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_dbg_start,
    input  logic             i_dbg_ready,
    output logic             o_dbg_valid,
    output logic [AW-1:0]    o_dbg_addr,
    output logic [WIDTH-1:0] o_dbg_data,
    output logic             o_dbg_busy,
    output logic             o_dbg_done
);

    typedef enum logic [1:0] {StIdle, StDump, StDone} state_e;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    state_e           state_q, state_d;
    logic [AW-1:0]    index_q, index_d;
    logic             wr_ok;
    logic             rd_ok_a, rd_ok_b;
    logic             beat_xfer;
    logic             last_beat;

    // A write lands only for an in-range address that is not the hardwired zero.
    always_comb begin
        wr_ok = i_wr_en && (32'(i_wr_addr) < NUM_REGS) &&
                !((ZERO_REG != 0) && (i_wr_addr == '0));
    end

    // Register array update; reset clears every register and beats any write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port A: out-of-range and hardwired-zero reads return 0; optional bypass.
    always_comb begin
        rd_ok_a     = (32'(i_rd_addr_a) < NUM_REGS) &&
                      !((ZERO_REG != 0) && (i_rd_addr_a == '0));
        o_rd_data_a = '0;
        if (rd_ok_a) begin
            if ((BYPASS != 0) && wr_ok && (i_wr_addr == i_rd_addr_a)) begin
                o_rd_data_a = i_wr_data;
            end else begin
                o_rd_data_a = regs_q[i_rd_addr_a];
            end
        end
    end

    // Read port B: identical to port A, fully independent.
    always_comb begin
        rd_ok_b     = (32'(i_rd_addr_b) < NUM_REGS) &&
                      !((ZERO_REG != 0) && (i_rd_addr_b == '0));
        o_rd_data_b = '0;
        if (rd_ok_b) begin
            if ((BYPASS != 0) && wr_ok && (i_wr_addr == i_rd_addr_b)) begin
                o_rd_data_b = i_wr_data;
            end else begin
                o_rd_data_b = regs_q[i_rd_addr_b];
            end
        end
    end

    // Dump FSM state and beat index registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    // Dump FSM next state and outputs; the dump reads stored values, never the bypass.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        o_dbg_valid = 1'b0;
        o_dbg_addr  = '0;
        o_dbg_data  = '0;
        o_dbg_busy  = 1'b0;
        o_dbg_done  = 1'b0;
        beat_xfer   = 1'b0;
        last_beat   = (32'(index_q) == NUM_REGS - 1);
        unique case (state_q)
            StIdle: begin
                if (i_dbg_start) begin
                    state_d = StDump;
                    index_d = '0;
                end
            end
            StDump: begin
                o_dbg_valid = 1'b1;
                o_dbg_busy  = 1'b1;
                o_dbg_addr  = index_q;
                if (!((ZERO_REG != 0) && (index_q == '0))) begin
                    o_dbg_data = regs_q[index_q];
                end
                beat_xfer = i_dbg_ready;
                if (beat_xfer) begin
                    if (last_beat) begin
                        state_d = StDone;
                        index_d = '0;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            StDone: begin
                o_dbg_busy = 1'b1;
                o_dbg_done = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule
